// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath: accumulator FSM states,
// datapath widths and the block-length decode.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    localparam int PROD_W    = 8;
    localparam int LEN_W     = 4;
    localparam int ACC_W_DEF = 12;

    // A programmed length of 0 encodes a full block of 16 products.
    function automatic logic [4:0] len_to_remain(input logic [LEN_W-1:0] len_v);
        logic [4:0] r;
        if (len_v == 4'd0) begin
            r = 5'd16;
        end else begin
            r = {1'b0, len_v};
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_accum.sv
// Block accumulator behind the 4x4 multiplier: sums a programmed number of
// 8-bit products over valid/ready and presents the total with a sticky overflow.
module mult_accum
    import mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf,
    output logic              busy
);

    localparam int EXT_W = ACC_W + 1 - PROD_W;

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       remain_q, remain_d;
    logic [ACC_W:0]   add_s;

    // Handshake flags decode straight from the state register, so neither
    // in_valid nor out_ready has a combinational path to them.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign sum       = acc_q;
    assign ovf       = ovf_q;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign add_s = {1'b0, acc_q} + {{EXT_W{1'b0}}, product};

    // Next-state logic: abort dominates, then the per-state behaviour.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        remain_d = remain_q;
        if (abort) begin
            state_d  = IDLE;
            acc_d    = {ACC_W{1'b0}};
            ovf_d    = 1'b0;
            remain_d = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = ACCUM;
                        acc_d    = {ACC_W{1'b0}};
                        ovf_d    = 1'b0;
                        remain_d = len_to_remain(len);
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_d    = add_s[ACC_W-1:0];
                        ovf_d    = ovf_q | add_s[ACC_W];
                        remain_d = remain_q - 5'd1;
                        if (remain_q == 5'd1) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    acc_d    = {ACC_W{1'b0}};
                    ovf_d    = 1'b0;
                    remain_d = 5'd0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= {ACC_W{1'b0}};
            ovf_q    <= 1'b0;
            remain_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            remain_q <= remain_d;
        end
    end

endmodule

// File: tb/tb_mult_accum.sv
// Self-checking bench for mult_accum: a 12-bit and an 8-bit instance share the
// stimulus and are compared every cycle against an unbounded-total model.
module tb_mult_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] len = 4'd0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] product = 8'd0;
    logic       out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, ovf_a, busy_a;
    logic [11:0] sum_a;
    logic        in_ready_b, out_valid_b, ovf_b, busy_b;
    logic [7:0]  sum_b;

    int checks = 0;
    int failures = 0;

    // Model: remaining beats, pending result and the true (unwrapped) total.
    int m_left = 0;
    bit m_pend = 1'b0;
    int m_total = 0;

    always #5 clk = ~clk;

    mult_accum #(.ACC_W(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_a), .product(product),
        .out_valid(out_valid_a), .out_ready(out_ready), .sum(sum_a),
        .ovf(ovf_a), .busy(busy_a)
    );

    mult_accum #(.ACC_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_b), .product(product),
        .out_valid(out_valid_b), .out_ready(out_ready), .sum(sum_b),
        .ovf(ovf_b), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the block protocol.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_pend  <= 1'b0;
            m_total <= 0;
        end else if (abort) begin
            m_left  <= 0;
            m_pend  <= 1'b0;
            m_total <= 0;
        end else if (m_left > 0) begin
            if (in_valid) begin
                m_total <= m_total + int'(product);
                m_left  <= m_left - 1;
                if (m_left == 1) m_pend <= 1'b1;
            end
        end else if (m_pend) begin
            if (out_ready) m_pend <= 1'b0;
        end else if (start) begin
            m_left  <= (len == 4'd0) ? 16 : int'(len);
            m_total <= 0;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("in_ready12",  int'(in_ready_a),  int'(m_left > 0));
        chk("out_valid12", int'(out_valid_a), int'(m_pend));
        chk("busy12",      int'(busy_a),      int'(m_left > 0 || m_pend));
        chk("sum12",       int'(sum_a),       m_total % 4096);
        chk("ovf12",       int'(ovf_a),       int'(m_total >= 4096));
        chk("in_ready8",   int'(in_ready_b),  int'(m_left > 0));
        chk("out_valid8",  int'(out_valid_b), int'(m_pend));
        chk("busy8",       int'(busy_b),      int'(m_left > 0 || m_pend));
        chk("sum8",        int'(sum_b),       m_total % 256);
        chk("ovf8",        int'(ovf_b),       int'(m_total >= 256));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        rst_n = 1'b1;
        chk("rst_in_ready", int'(in_ready_a), 0);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_sum", int'(sum_a), 0);
        chk("rst_ovf", int'(ovf_a), 0);
        cyc();

        // Reset mid-block.
        start = 1'b1; len = 4'd3;
        cyc();
        start = 1'b0;
        chk("mid_busy_before", int'(busy_a), 1);
        in_valid = 1'b1; product = 8'd10;
        cyc();
        in_valid = 1'b0;
        chk("mid_partial", int'(sum_a), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", int'(sum_a), 0);
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_in_ready", int'(in_ready_a), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("mid_idle_in_ready", int'(in_ready_a), 0);
        chk("mid_idle_busy", int'(busy_a), 0);

        // Basic block 225 + 1 + 2.
        start = 1'b1; len = 4'd3;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        product = 8'd225; cyc();
        product = 8'd1;   cyc();
        product = 8'd2;   cyc();
        in_valid = 1'b0;
        chk("basic_out_valid", int'(out_valid_a), 1);
        chk("basic_in_ready", int'(in_ready_a), 0);
        chk("basic_sum", int'(sum_a), 228);
        chk("basic_ovf", int'(ovf_a), 0);
        chk("basic_model", m_total, 228);
        handshake();
        chk("basic_done", int'(out_valid_a), 0);
        chk("basic_keep_sum", int'(sum_a), 228);

        // len=0 with every-other-cycle gaps; extra valid cycles must be refused.
        start = 1'b1; len = 4'd0;
        cyc();
        start = 1'b0;
        product = 8'd225;
        for (int i = 0; i < 36; i++) begin
            in_valid = (i % 2 == 0);
            cyc();
        end
        in_valid = 1'b0;
        chk("len0_sum", int'(sum_a), 3600);
        chk("len0_ovf", int'(ovf_a), 0);
        chk("len0_out_valid", int'(out_valid_a), 1);
        chk("len0_sum8", int'(sum_b), 16);
        chk("len0_ovf8", int'(ovf_b), 1);
        handshake();

        // Overflow on the 8-bit instance, then cleared by the next start.
        start = 1'b1; len = 4'd2;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        product = 8'd200; cyc();
        product = 8'd100; cyc();
        in_valid = 1'b0;
        chk("ovf_sum8", int'(sum_b), 44);
        chk("ovf_flag8", int'(ovf_b), 1);
        chk("ovf_sum12", int'(sum_a), 300);
        chk("ovf_flag12", int'(ovf_a), 0);
        handshake();
        chk("ovf_sticky_idle", int'(ovf_b), 1);
        start = 1'b1; len = 4'd1;
        cyc();
        start = 1'b0;
        chk("ovf_cleared", int'(ovf_b), 0);
        in_valid = 1'b1; product = 8'd5;
        cyc();
        in_valid = 1'b0;
        chk("ovf_next_sum8", int'(sum_b), 5);
        chk("ovf_next_flag8", int'(ovf_b), 0);
        handshake();

        // Backpressure in HOLD with start/in_valid pulsing.
        start = 1'b1; len = 4'd1;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; product = 8'd9;
        cyc();
        product = 8'd50;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            in_valid = 1'b1;
            cyc();
        end
        start = 1'b0; in_valid = 1'b0;
        chk("bp_sum", int'(sum_a), 9);
        chk("bp_out_valid", int'(out_valid_a), 1);
        start = 1'b1;
        handshake();
        start = 1'b0;
        chk("bp_start_ignored", int'(busy_a), 0);
        start = 1'b1; len = 4'd1;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; product = 8'd7;
        cyc();
        in_valid = 1'b0;
        chk("bp_next_sum", int'(sum_a), 7);
        handshake();

        // Abort with a concurrent valid beat.
        start = 1'b1; len = 4'd4;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        product = 8'd50; cyc();
        product = 8'd60; cyc();
        chk("abort_partial", int'(sum_a), 110);
        abort = 1'b1; product = 8'd70;
        cyc();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_out_valid", int'(out_valid_a), 0);
        chk("abort_ovf", int'(ovf_a), 0);
        chk("abort_sum", int'(sum_a), 0);
        cyc();
        cyc();
        abort = 1'b1; start = 1'b1; len = 4'd2;
        cyc();
        abort = 1'b0; start = 1'b0;
        chk("abort_start_idle", int'(busy_a), 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
